// File: rtl/io_bus_router.sv
// io_bus_router: decodes CPU accesses in a 256-byte I/O window onto NUM_CH channels,
// stalls the CPU until the channel acks or times out. Optional macro: IO_BUS_ERR_STATUS_EN.
module io_bus_router #(
    parameter int                   NUM_CH       = 4,
    parameter logic [23:0]          IO_BASE      = 24'h2000,
    parameter logic [NUM_CH*8-1:0]  CH_LO        = {8'hFE, 8'h80, 8'h20, 8'h00},
    parameter logic [NUM_CH*8-1:0]  CH_HI        = {8'hFF, 8'h8F, 8'h3F, 8'h1F},
    parameter int                   TIMEOUT      = 15,
    parameter logic [7:0]           OPEN_BUS     = 8'hFF,
    parameter logic [1:0]           MEM_READ_CMD = 2'b01
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [23:0]           cpu_addr,
    input  logic [1:0]            cpu_bus_status,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [7:0]            cpu_wdata,
    output logic [7:0]            cpu_rdata,
    output logic                  cpu_wait,
    input  logic [7:0]            ext_rdata,
    output logic [NUM_CH-1:0]     ch_sel,
    output logic                  ch_rd,
    output logic                  ch_wr,
    output logic [7:0]            ch_offset,
    output logic [7:0]            ch_wdata,
    input  logic [NUM_CH*8-1:0]   ch_rdata,
    input  logic [NUM_CH-1:0]     ch_ack,
    output logic                  bus_err
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state_reg, state_next;
    logic [NUM_CH-1:0]   sel_reg, sel_next;
    logic                is_rd_reg, is_rd_next;
    logic                rd_reg, rd_next;
    logic                wr_reg, wr_next;
    logic [7:0]          offset_reg, offset_next;
    logic [7:0]          wdata_reg, wdata_next;
    logic [7:0]          cnt_reg, cnt_next;
    logic [7:0]          rdata_reg, rdata_next;

    logic [24:0]         addr_ext;
    logic [24:0]         win_lo;
    logic                in_win;
    logic [7:0]          off;
    logic                strobe;
    logic [NUM_CH-1:0]   hit_vec;
    logic [NUM_CH-1:0]   hit_onehot;
    logic                any_hit;
    logic                ack_sel;
    logic [7:0]          sel_rdata;
    logic [7:0]          cnt_inc;
    logic                status_hit;

    // One extra bit keeps IO_BASE+256 from wrapping at the top of the address space.
    assign addr_ext = {1'b0, cpu_addr};
    assign win_lo   = {1'b0, IO_BASE};
    assign in_win   = (addr_ext >= win_lo) && (addr_ext < win_lo + 25'd256);
    assign off      = cpu_addr[7:0];
    assign strobe   = cpu_read | cpu_write;
    assign cnt_inc  = cnt_reg + 8'd1;
    assign ack_sel  = |(ch_ack & sel_reg);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_hit
        assign hit_vec[gi] = (off >= CH_LO[gi*8 +: 8]) && (off <= CH_HI[gi*8 +: 8]);
    end

    assign any_hit = |hit_vec;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit_onehot = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_onehot    = '0;
                hit_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_rdata = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_reg[i]) sel_rdata = sel_rdata | ch_rdata[i*8 +: 8];
        end
    end

`ifdef IO_BUS_ERR_STATUS_EN
    logic [7:0] err_status_reg, err_status_next;
    logic       bus_err_reg, bus_err_next;
    logic [2:0] sel_idx;

    assign status_hit = (off == 8'hF0);
    assign bus_err    = bus_err_reg;

    always_comb begin
        sel_idx = 3'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_reg[i]) sel_idx = 3'(i);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_status_reg <= 8'h00;
            bus_err_reg    <= 1'b0;
        end else begin
            err_status_reg <= err_status_next;
            bus_err_reg    <= bus_err_next;
        end
    end
`else
    assign status_hit = 1'b0;
    assign bus_err    = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        is_rd_next  = is_rd_reg;
        rd_next     = 1'b0;
        wr_next     = 1'b0;
        offset_next = offset_reg;
        wdata_next  = wdata_reg;
        cnt_next    = cnt_reg;
        rdata_next  = rdata_reg;
        cpu_wait    = 1'b0;
`ifdef IO_BUS_ERR_STATUS_EN
        err_status_next = err_status_reg;
        bus_err_next    = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (strobe && in_win) begin
                    if (status_hit) begin
`ifdef IO_BUS_ERR_STATUS_EN
                        if (cpu_write) err_status_next = 8'h00;
                        else           rdata_next      = err_status_reg;
`endif
                    end else if (any_hit) begin
                        cpu_wait    = 1'b1;
                        sel_next    = hit_onehot;
                        offset_next = off;
                        wdata_next  = cpu_wdata;
                        is_rd_next  = ~cpu_write;
                        rd_next     = ~cpu_write;
                        wr_next     = cpu_write;
                        cnt_next    = 8'd0;
                        state_next  = ACCESS;
                    end else if (!cpu_write) begin
                        rdata_next = OPEN_BUS;
                    end
                end
            end
            ACCESS: begin
                cpu_wait = 1'b1;
                // Ack is checked before the counter so a last-cycle ack still succeeds.
                if (ack_sel) begin
                    if (is_rd_reg) rdata_next = sel_rdata;
                    sel_next   = '0;
                    state_next = IDLE;
                end else if (cnt_inc == 8'(TIMEOUT)) begin
                    if (is_rd_reg) rdata_next = OPEN_BUS;
                    cnt_next   = cnt_inc;
                    sel_next   = '0;
                    state_next = IDLE;
`ifdef IO_BUS_ERR_STATUS_EN
                    bus_err_next    = 1'b1;
                    err_status_next = {1'b1, 4'b0000, sel_idx};
`endif
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            sel_reg    <= '0;
            is_rd_reg  <= 1'b0;
            rd_reg     <= 1'b0;
            wr_reg     <= 1'b0;
            offset_reg <= 8'h00;
            wdata_reg  <= 8'h00;
            cnt_reg    <= 8'h00;
            rdata_reg  <= 8'h00;
        end else begin
            state_reg  <= state_next;
            sel_reg    <= sel_next;
            is_rd_reg  <= is_rd_next;
            rd_reg     <= rd_next;
            wr_reg     <= wr_next;
            offset_reg <= offset_next;
            wdata_reg  <= wdata_next;
            cnt_reg    <= cnt_next;
            rdata_reg  <= rdata_next;
        end
    end

    assign ch_sel    = sel_reg;
    assign ch_rd     = rd_reg;
    assign ch_wr     = wr_reg;
    assign ch_offset = offset_reg;
    assign ch_wdata  = wdata_reg;
    assign cpu_rdata = (in_win && (cpu_bus_status == MEM_READ_CMD)) ? rdata_reg : ext_rdata;

endmodule
